// File: rtl/evu_pkg.sv
// Shared types and default widths for the event arbiter.
// EVU_ARB_TIMESTAMP_EN adds a 32-bit grant timestamp to the packet.
package evu_pkg;

  localparam int EVU_NUM_SRC = 4;
  localparam int EVU_CNT_W   = 4;
  localparam int EVU_INFO_W  = 18;
  localparam int EVU_SRC_W   = $clog2(EVU_NUM_SRC);
  localparam int EVU_TS_W    = 32;

  typedef struct packed {
    logic [EVU_SRC_W-1:0]  src;
    logic [EVU_INFO_W-1:0] info;
`ifdef EVU_ARB_TIMESTAMP_EN
    logic [EVU_TS_W-1:0]   ts;
`endif
  } evu_pkt_t;

endpackage

// File: rtl/evu_rr_picker.sv
// Round-robin search: first set request after i_last,
// wrapping from N-1 back to 0.
module evu_rr_picker #(
  parameter int N     = 4,
  parameter int SRC_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SRC_W-1:0] i_last,
  output logic             o_valid,
  output logic [SRC_W-1:0] o_idx
);

  int w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_last) + k) % N;
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = SRC_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/evu_event_arbiter.sv
// Per-source pending counters feeding a round-robin packet register.
// Define EVU_ARB_TIMESTAMP_EN to add ev_ts_o and its cycle counter.
module evu_event_arbiter
  import evu_pkg::*;
#(
  parameter int NUM_SRC    = EVU_NUM_SRC,
  parameter int CNT_WIDTH  = EVU_CNT_W,
  parameter int INFO_WIDTH = EVU_INFO_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_SRC-1:0]         event_i,
  input  logic [NUM_SRC-1:0]         en_i,
  input  logic [INFO_WIDTH-1:0]      info_i,
  input  logic [NUM_SRC-1:0]         clr_ovf_i,
  output logic                       ev_valid_o,
  input  logic                       ev_ready_i,
  output logic [$clog2(NUM_SRC)-1:0] ev_src_o,
  output logic [INFO_WIDTH-1:0]      ev_info_o,
`ifdef EVU_ARB_TIMESTAMP_EN
  output logic [EVU_TS_W-1:0]        ev_ts_o,
`endif
  output logic [NUM_SRC-1:0]         ev_ovf_o
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_cnt     [NUM_SRC];
  logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_SRC];
  logic [NUM_SRC-1:0]   w_req;
  logic [NUM_SRC-1:0]   w_inc;
  logic [NUM_SRC-1:0]   w_dec;
  logic [NUM_SRC-1:0]   w_ovf_set;
  logic [NUM_SRC-1:0]   r_ovf;
  logic [SRC_W-1:0]     r_last;
  logic [SRC_W-1:0]     w_pick_idx;
  logic                 w_pick_vld;
  logic                 w_free;
  logic                 w_grant;
  logic                 r_valid;
  evu_pkt_t             r_pkt;
  evu_pkt_t             w_pkt_nxt;

`ifdef EVU_ARB_TIMESTAMP_EN
  logic [EVU_TS_W-1:0]  r_ts;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ts <= '0;
    else         r_ts <= r_ts + 1'b1;
  end

  assign ev_ts_o = r_pkt.ts;
`endif

  evu_rr_picker #(
    .N     (NUM_SRC),
    .SRC_W (SRC_W)
  ) u_picker (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  assign w_free  = !r_valid || ev_ready_i;
  assign w_grant = w_free && w_pick_vld;

  // Increment and decrement in the same cycle cancel,
  // so a saturated counter only overflows without a grant.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_req[i]     = |r_cnt[i];
      w_inc[i]     = event_i[i] && en_i[i];
      w_dec[i]     = w_grant && (w_pick_idx == SRC_W'(i));
      w_ovf_set[i] = w_inc[i] && !w_dec[i]
                     && (r_cnt[i] == CNT_MAX);
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc[i] && !w_dec[i] && !w_ovf_set[i])
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      else if (w_dec[i] && !w_inc[i])
        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
    end
  end

  always_comb begin
    w_pkt_nxt      = r_pkt;
    w_pkt_nxt.src  = EVU_SRC_W'(w_pick_idx);
    w_pkt_nxt.info = EVU_INFO_W'(info_i);
`ifdef EVU_ARB_TIMESTAMP_EN
    w_pkt_nxt.ts   = r_ts;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
      r_ovf   <= '0;
      r_last  <= SRC_W'(NUM_SRC - 1);
      r_valid <= 1'b0;
      r_pkt   <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_ovf <= (r_ovf & ~clr_ovf_i) | w_ovf_set;
      if (w_grant) begin
        r_last  <= w_pick_idx;
        r_valid <= 1'b1;
        r_pkt   <= w_pkt_nxt;
      end else if (r_valid && ev_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ev_valid_o = r_valid;
  assign ev_src_o   = SRC_W'(r_pkt.src);
  assign ev_info_o  = INFO_WIDTH'(r_pkt.info);
  assign ev_ovf_o   = r_ovf;

endmodule

// File: tb/tb_evu_event_arbiter.sv
// Directed bench for evu_event_arbiter (4 sources, 4-bit counters).
// Inputs change and outputs are sampled on the falling edge.
module tb_evu_event_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  event_i;
  logic [3:0]  en_i;
  logic [17:0] info_i;
  logic [3:0]  clr_ovf_i;
  logic        ev_valid_o;
  logic        ev_ready_i;
  logic [1:0]  ev_src_o;
  logic [17:0] ev_info_o;
  logic [3:0]  ev_ovf_o;
`ifdef EVU_ARB_TIMESTAMP_EN
  logic [31:0] ev_ts_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  evu_event_arbiter dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .event_i    (event_i),
    .en_i       (en_i),
    .info_i     (info_i),
    .clr_ovf_i  (clr_ovf_i),
    .ev_valid_o (ev_valid_o),
    .ev_ready_i (ev_ready_i),
    .ev_src_o   (ev_src_o),
    .ev_info_o  (ev_info_o),
`ifdef EVU_ARB_TIMESTAMP_EN
    .ev_ts_o    (ev_ts_o),
`endif
    .ev_ovf_o   (ev_ovf_o)
  );

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    event_i = '0; en_i = '1; info_i = '0;
    clr_ovf_i = '0; ev_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (ev_valid_o !== 1'b0) begin
      $display("FAIL reset_valid: got %b want 0", ev_valid_o); n_err++;
    end
    n_vec++;
    if (ev_src_o !== 2'd0 || ev_info_o !== 18'd0) begin
      $display("FAIL reset_pkt: got src=%0d info=%h want 0/0",
               ev_src_o, ev_info_o); n_err++;
    end
    n_vec++;
    if (ev_ovf_o !== 4'b0000) begin
      $display("FAIL reset_ovf: got %b want 0000", ev_ovf_o); n_err++;
    end
  endtask

  task automatic test_single();
    do_reset();
    event_i = 4'b0001; info_i = 18'h2A5C3;
    @(negedge clk_i);
    event_i = '0; info_i = 18'h00011;
    n_vec++;
    if (ev_valid_o !== 1'b0) begin
      $display("FAIL single_early: got valid=%b want 0", ev_valid_o); n_err++;
    end
    @(negedge clk_i);
    n_vec++;
    if (ev_valid_o !== 1'b1 || ev_src_o !== 2'd0 || ev_info_o !== 18'h00011) begin
      $display("FAIL single_pkt: got v=%b src=%0d info=%h want 1/0/00011",
               ev_valid_o, ev_src_o, ev_info_o); n_err++;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (ev_valid_o !== 1'b0) begin
        $display("FAIL single_extra: cycle %0d got valid=%b want 0",
                 c, ev_valid_o); n_err++;
      end
    end
  endtask

  task automatic test_all_sources();
    do_reset();
    event_i = 4'b1111;
    @(negedge clk_i);
    event_i = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      n_vec++;
      if (ev_valid_o !== 1'b1 || ev_src_o !== 2'(k)) begin
        $display("FAIL rr_order: slot %0d got v=%b src=%0d want 1/%0d",
                 k, ev_valid_o, ev_src_o, k); n_err++;
      end
    end
    @(negedge clk_i);
    n_vec++;
    if (ev_valid_o !== 1'b0) begin
      $display("FAIL rr_done: got valid=%b want 0", ev_valid_o); n_err++;
    end
  endtask

  // 17 pulses: one goes out as the held packet, 15 fill the
  // counter, the last hits saturation and sets the flag.
  task automatic test_overflow();
    int seen;
    do_reset();
    ev_ready_i = 1'b0;
    for (int c = 0; c < 17; c++) begin
      event_i = 4'b0100;
      @(negedge clk_i);
    end
    event_i = '0;
    n_vec++;
    if (ev_ovf_o !== 4'b0100) begin
      $display("FAIL ovf_set: got %b want 0100", ev_ovf_o); n_err++;
    end
    n_vec++;
    if (ev_valid_o !== 1'b1 || ev_src_o !== 2'd2) begin
      $display("FAIL ovf_held: got v=%b src=%0d want 1/2",
               ev_valid_o, ev_src_o); n_err++;
    end
    event_i = 4'b0100; clr_ovf_i = 4'b0100;
    @(negedge clk_i);
    event_i = '0;
    n_vec++;
    if (ev_ovf_o !== 4'b0100) begin
      $display("FAIL ovf_set_wins: got %b want 0100", ev_ovf_o); n_err++;
    end
    @(negedge clk_i);
    clr_ovf_i = '0;
    n_vec++;
    if (ev_ovf_o !== 4'b0000) begin
      $display("FAIL ovf_clear: got %b want 0000", ev_ovf_o); n_err++;
    end
    ev_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (ev_valid_o === 1'b1 && ev_src_o === 2'd2) seen++;
    end
    n_vec++;
    if (seen !== 15) begin
      $display("FAIL ovf_drain: got %0d packets after held one want 15", seen);
      n_err++;
    end
  endtask

  task automatic test_enable();
    int seen;
    do_reset();
    en_i = 4'b1011;
    event_i = 4'b0100;
    repeat (3) @(negedge clk_i);
    event_i = '0;
    repeat (2) @(negedge clk_i);
    n_vec++;
    if (ev_valid_o !== 1'b0 || ev_ovf_o !== 4'b0000) begin
      $display("FAIL en_drop: got v=%b ovf=%b want 0/0000",
               ev_valid_o, ev_ovf_o); n_err++;
    end
    ev_ready_i = 1'b0;
    en_i = 4'b1111; event_i = 4'b0010;
    repeat (3) @(negedge clk_i);
    event_i = '0;
    en_i = 4'b0000;
    @(negedge clk_i);
    ev_ready_i = 1'b1;
    seen = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (ev_valid_o === 1'b1 && ev_src_o === 2'd1) seen++;
    end
    n_vec++;
    if (seen !== 3) begin
      $display("FAIL en_drain: got %0d packets want 3", seen); n_err++;
    end
  endtask

  task automatic test_hold();
    do_reset();
    ev_ready_i = 1'b0;
    event_i = 4'b0001; info_i = 18'h01234;
    @(negedge clk_i);
    event_i = 4'b1000;
    @(negedge clk_i);
    event_i = '0;
    for (int c = 0; c < 3; c++) begin
      info_i = 18'h3F000 + 18'(c);
      @(negedge clk_i);
      n_vec++;
      if (ev_valid_o !== 1'b1 || ev_src_o !== 2'd0 || ev_info_o !== 18'h01234) begin
        $display("FAIL hold_stable: c=%0d got v=%b src=%0d info=%h want 1/0/01234",
                 c, ev_valid_o, ev_src_o, ev_info_o); n_err++;
      end
    end
    info_i = 18'h2BEEF;
    ev_ready_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (ev_valid_o !== 1'b1 || ev_src_o !== 2'd3 || ev_info_o !== 18'h2BEEF) begin
      $display("FAIL hold_next: got v=%b src=%0d info=%h want 1/3/2beef",
               ev_valid_o, ev_src_o, ev_info_o); n_err++;
    end
    @(negedge clk_i);
    n_vec++;
    if (ev_valid_o !== 1'b0) begin
      $display("FAIL hold_idle: got valid=%b want 0", ev_valid_o); n_err++;
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    ev_ready_i = 1'b0;
    event_i = 4'b0010;
    repeat (3) @(negedge clk_i);
    event_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (ev_valid_o !== 1'b0) begin
      $display("FAIL rst_mid_valid: got %b want 0", ev_valid_o); n_err++;
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    ev_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (ev_valid_o !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      $display("FAIL rst_mid_drain: got %0d valid cycles want 0", seen); n_err++;
    end
  endtask

`ifdef EVU_ARB_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    repeat (10) @(negedge clk_i);
    event_i = 4'b0001;
    @(negedge clk_i);
    event_i = '0;
    @(negedge clk_i);
    n_vec++;
    if (ev_valid_o !== 1'b1 || ev_ts_o !== 32'd11) begin
      $display("FAIL ts_value: got v=%b ts=%0d want 1/11",
               ev_valid_o, ev_ts_o); n_err++;
    end
  endtask
`endif

  initial begin
    rst_ni = 1'b0;
    event_i = '0; en_i = '1; info_i = '0;
    clr_ovf_i = '0; ev_ready_i = 1'b1;
    test_reset();
    test_single();
    test_all_sources();
    test_overflow();
    test_enable();
    test_hold();
    test_reset_mid();
`ifdef EVU_ARB_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
